// File: rtl/cv_mem_pkg.sv
// cv_mem_pkg
//   Shared types and constants for the Colecovision external memory arbiter.
//   - cv_mem_state_e : arbiter sequencer state (IDLE / ACCESS)
//   - cv_mem_gnt_e   : which requester owns the memory port (GNT_CPU / GNT_LOADER)
//   - CV_MEM_RESET_Q : value presented on the CPU read-data bus out of reset
package cv_mem_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } cv_mem_state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_LOADER
  } cv_mem_gnt_e;

  // Reads of unbacked memory float high on the real bus, so idle read data mirrors that.
  localparam logic [7:0] CV_MEM_RESET_Q = 8'hFF;

endpackage

// File: rtl/cv_mem_arb_if.sv
// cv_mem_arb_if
//   Bundles the three buses around the external memory arbiter.
//   Signal suffixes are written from the arbiter's point of view.
//   CPU side   : cpu_req_i, cpu_we_i, cpu_addr_i, cpu_d_i -> cpu_q_o, cpu_wait_n_o
//   Loader side: ld_req_i, ld_addr_i, ld_d_i              -> ld_ack_o
//   Memory side: mem_q_i -> mem_ce_o, mem_we_o, mem_addr_o, mem_d_o
//   modport slave  : the arbiter itself
//   modport master : whatever surrounds it (Z80 glue, loader, memory)
interface cv_mem_arb_if #(
  parameter int ADDR_W = 20
);

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [7:0]        cpu_d_i;
  logic [7:0]        cpu_q_o;
  logic              cpu_wait_n_o;

  logic              ld_req_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [7:0]        ld_d_i;
  logic              ld_ack_o;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_d_o;
  logic [7:0]        mem_q_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_d_i,
    input  ld_req_i, ld_addr_i, ld_d_i,
    input  mem_q_i,
    output cpu_q_o, cpu_wait_n_o, ld_ack_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_d_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_d_i,
    output ld_req_i, ld_addr_i, ld_d_i,
    output mem_q_i,
    input  cpu_q_o, cpu_wait_n_o, ld_ack_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_d_o
  );

endinterface

// File: rtl/cv_mem_arb.sv
// cv_mem_arb
//   Serialises Z80 memory cycles and loader writes onto one registered
//   byte-wide memory port. The Z80 is held in WAIT until its access has
//   completed; under contention the grant alternates between requesters.
//   Parameters:
//     ADDR_W  : memory address width
//     MEM_LAT : cycles from grant to valid read data (1..15)
//   Ports:
//     clk_i   : system clock
//     reset_i : asynchronous active-high reset
//     bus     : cv_mem_arb_if.slave (CPU, loader and memory buses)
module cv_mem_arb
  import cv_mem_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int MEM_LAT = 2
) (
  input logic         clk_i,
  input logic         reset_i,
  cv_mem_arb_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  cv_mem_state_e     state_q;
  logic [3:0]        cnt_q;
  cv_mem_gnt_e       lastGrant_q;
  cv_mem_gnt_e       owner_q;
  logic              cpuDone_q;
  logic              cpuDone_d;
  logic [7:0]        cpuQ_q;
  logic              ldAck_q;
  logic              memCe_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [7:0]        memD_q;

  logic cpuElig;
  logic ldElig;
  logic grantCpu;
  logic accessEnd;
  logic cpuComplete;

  // A requester that has just been served is masked until it drops its request
  // (CPU) or until its ack cycle has passed (loader), so one request = one access.
  assign cpuElig  = bus.cpu_req_i & ~cpuDone_q;
  assign ldElig   = bus.ld_req_i & ~ldAck_q;
  assign grantCpu = cpuElig & (~ldElig | (lastGrant_q == GNT_LOADER));

  assign accessEnd   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign cpuComplete = accessEnd && (owner_q == GNT_CPU);

  // cpu_done survives only while the Z80 keeps its cycle open; a withdrawn
  // request never leaves a stale done flag behind.
  assign cpuDone_d = bus.cpu_req_i & (cpuDone_q | cpuComplete);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      lastGrant_q <= GNT_LOADER;
      owner_q     <= GNT_CPU;
      cpuDone_q   <= 1'b0;
      cpuQ_q      <= CV_MEM_RESET_Q;
      ldAck_q     <= 1'b0;
      memCe_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memD_q      <= 8'h00;
    end else begin
      ldAck_q   <= 1'b0;
      cpuDone_q <= cpuDone_d;
      case (state_q)
        IDLE: begin
          if (cpuElig || ldElig) begin
            state_q <= ACCESS;
            cnt_q   <= CNT_LOAD;
            memCe_q <= 1'b1;
            if (grantCpu) begin
              owner_q     <= GNT_CPU;
              lastGrant_q <= GNT_CPU;
              memWe_q     <= bus.cpu_we_i;
              memAddr_q   <= bus.cpu_addr_i;
              memD_q      <= bus.cpu_d_i;
            end else begin
              owner_q     <= GNT_LOADER;
              lastGrant_q <= GNT_LOADER;
              memWe_q     <= 1'b1;
              memAddr_q   <= bus.ld_addr_i;
              memD_q      <= bus.ld_d_i;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            memCe_q <= 1'b0;
            memWe_q <= 1'b0;
            // Read data is captured even if the Z80 already abandoned the cycle.
            if (owner_q == GNT_CPU) begin
              if (!memWe_q) begin
                cpuQ_q <= bus.mem_q_i;
              end
            end else begin
              ldAck_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_q_o      = cpuQ_q;
  assign bus.cpu_wait_n_o = ~cpuElig;
  assign bus.ld_ack_o     = ldAck_q;
  assign bus.mem_ce_o     = memCe_q;
  assign bus.mem_we_o     = memWe_q;
  assign bus.mem_addr_o   = memAddr_q;
  assign bus.mem_d_o      = memD_q;

endmodule

// File: tb/tb_cv_mem_arb.sv
// tb_cv_mem_arb
//   Directed bench for cv_mem_arb. A latency-accurate memory model returns a
//   fixed byte pattern per address, and only presents correct data once the
//   access has been open for MEM_LAT cycles. Expected memory operations are
//   queued per requester when stimulus is driven and popped on each grant.
//   Ports of the DUT: clk_i, reset_i, bus (cv_mem_arb_if).
module tb_cv_mem_arb;

  localparam int ADDR_W  = 20;
  localparam int MEM_LAT = 2;
  localparam int WORST_WAIT = 2 * (MEM_LAT + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        d;
  } memOp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cv_mem_arb_if #(.ADDR_W(ADDR_W)) bus ();

  cv_mem_arb #(
    .ADDR_W (ADDR_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  memOp_t cpuExp[$];
  memOp_t ldExp[$];
  memOp_t curOp = '0;
  logic   grantLog[$];
  int     compared = 0;
  int     mismatched = 0;
  int     ceAge = 0;
  int     burstLen = 0;
  int     grantCount = 0;
  logic   prevCe = 1'b0;

  function automatic logic [7:0] memByte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hDA;
  endfunction

  // Until the access has aged MEM_LAT cycles the memory shows inverted data,
  // so an early capture is visible.
  assign bus.mem_q_i = (ceAge >= MEM_LAT) ? memByte(bus.mem_addr_o) : ~memByte(bus.mem_addr_o);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic logAt(input int i);
    if (i < grantLog.size()) return grantLog[i];
    return 1'b0;
  endfunction

  // Memory-side scoreboard, evaluated at every falling edge.
  task automatic monitor();
    if (rst) begin
      prevCe   = 1'b0;
      ceAge    = 0;
      burstLen = 0;
      return;
    end
    if (bus.mem_ce_o && !prevCe) begin
      grantCount++;
      grantLog.push_back(bus.mem_we_o);
      checkOutput("sb_grant_expected",
                  32'((bus.mem_we_o ? ldExp.size() : cpuExp.size()) != 0), 32'(1));
      if (bus.mem_we_o && ldExp.size() != 0) curOp = ldExp.pop_front();
      else if (!bus.mem_we_o && cpuExp.size() != 0) curOp = cpuExp.pop_front();
    end
    if (bus.mem_ce_o) begin
      checkOutput("mem_bus", 32'({bus.mem_we_o, bus.mem_addr_o, bus.mem_d_o}), 32'(curOp));
      burstLen++;
    end else if (prevCe) begin
      checkOutput("burst_len", 32'(burstLen), 32'(MEM_LAT));
      burstLen = 0;
    end
    ceAge  = bus.mem_ce_o ? ceAge + 1 : 0;
    prevCe = bus.mem_ce_o;
  endtask

  task automatic toSample();
    @(negedge clk);
    monitor();
  endtask

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      toDrive();
      toSample();
    end
  endtask

  // Starts at a drive point with cpu_req_i already raised; ends at the sample
  // point where WAIT_n has been released.
  task automatic waitCpuDone(output int low);
    low = 0;
    toSample();
    while (!bus.cpu_wait_n_o && low < 40) begin
      low++;
      toDrive();
      toSample();
    end
    checkOutput("cpu_wait_bounded", 32'(low < 40), 32'(1));
  endtask

  // Serves whatever is requested, dropping each request once it has been
  // answered. Starts and ends at a drive point.
  task automatic applyStimulus(input string tag);
    bit cpuFin = 0;
    bit ldFin = 0;
    int n = 0;
    while ((bus.cpu_req_i || bus.ld_req_i) && n < 60) begin
      toSample();
      if (bus.cpu_req_i && bus.cpu_wait_n_o) cpuFin = 1;
      if (bus.ld_ack_o) ldFin = 1;
      toDrive();
      if (cpuFin) begin bus.cpu_req_i = 1'b0; cpuFin = 0; end
      if (ldFin) begin bus.ld_req_i = 1'b0; ldFin = 0; end
      n++;
    end
    checkOutput({tag, "_done"}, 32'(n < 60), 32'(1));
  endtask

  initial begin
    int low;
    int mark;
    int ldLeft;
    int k;
    bit cpuRaised;
    bit cpuFin;
    bit ackSeen;
    bit seen;

    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_d_i    = 8'h00;
    bus.ld_req_i   = 1'b0;
    bus.ld_addr_i  = '0;
    bus.ld_d_i     = 8'h00;

    // ---- reset state ----
    toDrive();
    toSample();
    checkOutput("rst_cpu_q", 32'(bus.cpu_q_o), 32'(8'hFF));
    checkOutput("rst_ld_ack", 32'(bus.ld_ack_o), 32'(0));
    checkOutput("rst_mem_ce", 32'(bus.mem_ce_o), 32'(0));
    checkOutput("rst_mem_we", 32'(bus.mem_we_o), 32'(0));
    checkOutput("rst_mem_addr", 32'(bus.mem_addr_o), 32'(0));
    checkOutput("rst_mem_d", 32'(bus.mem_d_o), 32'(0));
    checkOutput("rst_wait_n", 32'(bus.cpu_wait_n_o), 32'(1));
    toDrive();
    rst = 1'b0;
    toSample();

    // ---- contention straight out of reset: CPU first, then loader ----
    toDrive();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 20'h00100; bus.cpu_d_i = 8'h00;
    bus.ld_req_i  = 1'b1; bus.ld_addr_i = 20'h00200; bus.ld_d_i = 8'h11;
    cpuExp.push_back('{1'b0, 20'h00100, 8'h00});
    ldExp.push_back('{1'b1, 20'h00200, 8'h11});
    mark = grantLog.size();
    applyStimulus("contend1");
    checkOutput("contend1_grants", 32'(grantLog.size() - mark), 32'(2));
    checkOutput("contend1_first_cpu", 32'(logAt(mark)), 32'(0));
    checkOutput("contend1_second_ld", 32'(logAt(mark + 1)), 32'(1));
    checkOutput("contend1_cpu_q", 32'(bus.cpu_q_o), 32'(memByte(20'h00100)));

    // ---- single loader write with one-cycle ack ----
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 20'h01234; bus.ld_d_i = 8'hA5;
    ldExp.push_back('{1'b1, 20'h01234, 8'hA5});
    mark = grantCount;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      toSample();
      if (bus.ld_ack_o) seen = 1;
      else toDrive();
    end
    checkOutput("ld_ack_seen", 32'(seen), 32'(1));
    toDrive();
    bus.ld_req_i = 1'b0;
    toSample();
    checkOutput("ld_ack_one_cycle", 32'(bus.ld_ack_o), 32'(0));
    idle(3);
    checkOutput("ld_no_regrant", 32'(grantCount), 32'(mark + 1));

    // ---- CPU read, three wait cycles, then one access per Z80 cycle ----
    toDrive();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 20'h08000;
    cpuExp.push_back('{1'b0, 20'h08000, 8'h00});
    mark = grantCount;
    waitCpuDone(low);
    checkOutput("cpu_wait_cycles", 32'(low), 32'(MEM_LAT + 1));
    checkOutput("cpu_read_q", 32'(bus.cpu_q_o), 32'(8'h5A));
    idle(20);
    checkOutput("cpu_hold_wait_n", 32'(bus.cpu_wait_n_o), 32'(1));
    checkOutput("cpu_hold_single", 32'(grantCount), 32'(mark + 1));
    toDrive();
    bus.cpu_req_i = 1'b0;
    toSample();
    toDrive();
    bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 20'h08001;
    cpuExp.push_back('{1'b0, 20'h08001, 8'h00});
    waitCpuDone(low);
    checkOutput("cpu_second_q", 32'(bus.cpu_q_o), 32'(memByte(20'h08001)));
    checkOutput("cpu_second_access", 32'(grantCount), 32'(mark + 2));
    toDrive();
    bus.cpu_req_i = 1'b0;
    toSample();

    // ---- second contention: last grant was CPU, so loader goes first ----
    toDrive();
    bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 20'h00300;
    bus.ld_req_i  = 1'b1; bus.ld_addr_i = 20'h00400; bus.ld_d_i = 8'h22;
    cpuExp.push_back('{1'b0, 20'h00300, 8'h00});
    ldExp.push_back('{1'b1, 20'h00400, 8'h22});
    mark = grantLog.size();
    applyStimulus("contend2");
    checkOutput("contend2_grants", 32'(grantLog.size() - mark), 32'(2));
    checkOutput("contend2_first_ld", 32'(logAt(mark)), 32'(1));
    checkOutput("contend2_second_cpu", 32'(logAt(mark + 1)), 32'(0));
    checkOutput("contend2_cpu_q", 32'(bus.cpu_q_o), 32'(memByte(20'h00300)));

    // ---- continuous loader stream with a CPU read raised just after a loader grant ----
    k = 0;
    ldLeft = 4;
    cpuRaised = 0;
    cpuFin = 0;
    ackSeen = 0;
    low = 0;
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 20'h10000; bus.ld_d_i = 8'h40;
    ldExp.push_back('{1'b1, 20'h10000, 8'h40});
    for (int cyc = 0; cyc < 80 && (ldLeft > 0 || bus.cpu_req_i || !cpuRaised); cyc++) begin
      toSample();
      if (bus.cpu_req_i) begin
        if (bus.cpu_wait_n_o) cpuFin = 1;
        else low++;
      end
      if (bus.ld_ack_o) ackSeen = 1;
      if (!cpuRaised && bus.mem_ce_o && bus.mem_we_o && ceAge == 1) begin
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 20'h08123;
        cpuExp.push_back('{1'b0, 20'h08123, 8'h00});
        cpuRaised = 1;
      end
      toDrive();
      if (cpuFin) begin bus.cpu_req_i = 1'b0; cpuFin = 0; end
      if (ackSeen) begin
        ackSeen = 0;
        ldLeft--;
        if (ldLeft > 0) begin
          k++;
          bus.ld_addr_i = 20'h10000 + 20'(k);
          bus.ld_d_i    = 8'h40 + 8'(k);
          ldExp.push_back('{1'b1, 20'h10000 + 20'(k), 8'h40 + 8'(k)});
        end else begin
          bus.ld_req_i = 1'b0;
        end
      end
    end
    checkOutput("stream_ld_done", 32'(ldLeft), 32'(0));
    checkOutput("stream_cpu_served", 32'(cpuRaised && !bus.cpu_req_i), 32'(1));
    checkOutput("stream_cpu_wait_bound", 32'(low <= WORST_WAIT), 32'(1));
    checkOutput("stream_cpu_q", 32'(bus.cpu_q_o), 32'(memByte(20'h08123)));

    // ---- reset in the middle of a loader access ----
    bus.ld_req_i = 1'b1; bus.ld_addr_i = 20'h00777; bus.ld_d_i = 8'h99;
    ldExp.push_back('{1'b1, 20'h00777, 8'h99});
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      toSample();
      if (bus.mem_ce_o) seen = 1;
      else toDrive();
    end
    checkOutput("abort_access_started", 32'(seen), 32'(1));
    #2;
    rst = 1'b1;
    bus.ld_req_i = 1'b0;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 20'h08055;
    #1;
    checkOutput("abort_mem_ce", 32'(bus.mem_ce_o), 32'(0));
    checkOutput("abort_mem_we", 32'(bus.mem_we_o), 32'(0));
    checkOutput("abort_mem_addr", 32'(bus.mem_addr_o), 32'(0));
    checkOutput("abort_mem_d", 32'(bus.mem_d_o), 32'(0));
    checkOutput("abort_cpu_q", 32'(bus.cpu_q_o), 32'(8'hFF));
    checkOutput("abort_ld_ack", 32'(bus.ld_ack_o), 32'(0));
    toDrive();
    toSample();
    checkOutput("abort_no_ack", 32'(bus.ld_ack_o), 32'(0));
    toDrive();
    rst = 1'b0;
    cpuExp.push_back('{1'b0, 20'h08055, 8'h00});
    waitCpuDone(low);
    checkOutput("post_reset_cpu_wait", 32'(low), 32'(MEM_LAT + 1));
    checkOutput("post_reset_cpu_q", 32'(bus.cpu_q_o), 32'(memByte(20'h08055)));
    toDrive();
    bus.cpu_req_i = 1'b0;
    toSample();
    idle(3);

    checkOutput("cpu_queue_empty", 32'(cpuExp.size()), 32'(0));
    checkOutput("ld_queue_empty", 32'(ldExp.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
